// File: rtl/pt100_adc_uart_tx.sv
// PT100 sample serializer: two-byte UART packet on tx_o.
// Byte0 = {1, smp[9:3]}, byte1 = {00000, smp[2:0]}.
module pt100_adc_uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int STOP_BITS    = 2,
  parameter int GAP_BITS     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] sample_i,
  input  logic       sample_valid_i,
  output logic       sample_ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [3:0] GAP_LAST =
    (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]    state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [3:0]    cnt, cnt_n;
  logic          byte_sel, byte_sel_n;
  logic [7:0]    sh, sh_n;
  logic [9:0]    smp, smp_n;
  logic          done_n;
  logic          tx_n;
  logic          tick;
  logic          gap_exit;

  assign tick = (tmr == T_LAST);

  // Next-state logic: bit timer, FSM, counters and shift register
  always_comb begin
    state_n    = state;
    tmr_n      = tick ? '0 : tmr + TW'(1);
    cnt_n      = cnt;
    byte_sel_n = byte_sel;
    sh_n       = sh;
    smp_n      = smp;
    done_n     = 1'b0;
    gap_exit   = 1'b0;
    unique case (state)
      IDLE: begin
        tmr_n = '0;
        if (sample_valid_i && sample_ready_o) begin
          smp_n      = sample_i;
          sh_n       = {1'b1, sample_i[9:3]};
          byte_sel_n = 1'b0;
          state_n    = START;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          cnt_n   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt == 4'd7) begin
            state_n = STOP;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 4'd1;
            sh_n  = {1'b0, sh[7:1]};
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (cnt == STOP_LAST) begin
            cnt_n = '0;
            if (GAP_BITS == 0) gap_exit = 1'b1;
            else state_n = GAP;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (cnt == GAP_LAST) gap_exit = 1'b1;
          else cnt_n = cnt + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        tmr_n   = '0;
      end
    endcase
    if (gap_exit) begin
      cnt_n = '0;
      if (!byte_sel) begin
        byte_sel_n = 1'b1;
        sh_n       = {5'b00000, smp[2:0]};
        state_n    = START;
      end else begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end
  end

  // Line level follows the state being entered, so tx_o is a pure flop
  always_comb begin
    tx_n = 1'b1;
    if (state_n == START) tx_n = 1'b0;
    else if (state_n == DATA) tx_n = sh_n[0];
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      tmr            <= '0;
      cnt            <= '0;
      byte_sel       <= 1'b0;
      sh             <= '0;
      smp            <= '0;
      tx_o           <= 1'b1;
      sample_ready_o <= 1'b1;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      state          <= state_n;
      tmr            <= tmr_n;
      cnt            <= cnt_n;
      byte_sel       <= byte_sel_n;
      sh             <= sh_n;
      smp            <= smp_n;
      tx_o           <= tx_n;
      sample_ready_o <= (state_n == IDLE);
      busy_o         <= (state_n != IDLE);
      done_o         <= done_n;
    end
  end

endmodule

// File: tb/tb_pt100_adc_uart_tx.sv
// Bench for pt100_adc_uart_tx: mid-bit UART decoder plus
// packet-level reference model driven with random samples.
module tb_pt100_adc_uart_tx;

  localparam int CPB      = 4;
  localparam int BYTE_CYC = (9 + 2 + 1) * CPB;
  localparam int PKT_CYC  = 2 * BYTE_CYC;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] sample_i = '0;
  logic       sample_valid_i = 1'b0;
  logic       sample_ready_o;
  logic       tx_o;
  logic       busy_o;
  logic       done_o;

  pt100_adc_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS(2),
    .GAP_BITS(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_i(sample_i),
    .sample_valid_i(sample_valid_i),
    .sample_ready_o(sample_ready_o),
    .tx_o(tx_o),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] rx_b[$];
  int rx_s[$];
  bit rx_ok[$];
  int done_q[$];
  int low_q[$];
  int lowrun = 0;
  int busy_err = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference UART receiver: samples each bit in its middle
  initial forever begin : rx_mon
    int st;
    logic [7:0] b;
    bit sok;
    @(negedge clk);
    if (tx_o === 1'b0) begin
      st = cyc;
      sok = 1'b1;
      b = '0;
      repeat (2) @(negedge clk);
      if (tx_o !== 1'b0) sok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx_o;
      end
      for (int j = 0; j < 2; j++) begin
        repeat (CPB) @(negedge clk);
        if (tx_o !== 1'b1) sok = 1'b0;
      end
      rx_b.push_back(b);
      rx_s.push_back(st);
      rx_ok.push_back(sok);
    end
  end

  initial forever begin
    @(negedge clk);
    if (sample_ready_o !== 1'b1) lowrun++;
    else if (lowrun > 0) begin
      low_q.push_back(lowrun);
      lowrun = 0;
    end
    if (busy_o !== !sample_ready_o) busy_err++;
    if (done_o === 1'b1) done_q.push_back(cyc);
  end

  function automatic logic [15:0] model(input logic [9:0] s);
    int b0, b1;
    b0 = 128 + (int'(s) / 8);
    b1 = int'(s) % 8;
    return {8'(b0), 8'(b1)};
  endfunction

  task automatic clear_q();
    rx_b.delete();
    rx_s.delete();
    rx_ok.delete();
    done_q.delete();
    low_q.delete();
  endtask

  task automatic send(input logic [9:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sample_ready_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      sample_valid_i = 1'b1;
      sample_i = s;
      @(negedge clk);
      sample_valid_i = 1'b0;
      sample_i = 10'($urandom);
    end
  endtask

  task automatic wait_pkts(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 * n; i++) begin
      @(negedge clk);
      if (rx_b.size() >= 2 * n && done_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tx_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_tx got %b want 1", tx_o);
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_busy got %b want 0", busy_o);
    end
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_done got %b want 0", done_o);
    end
    n_cmp++;
    if (sample_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ready got %b want 1", sample_ready_o);
    end
    reset = 1'b0;
    clear_q();
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_o !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0 || rx_b.size() != 0 || done_q.size() != 0) begin
      n_bad++;
      $display("FAIL idle_line low=%0d bytes=%0d dones=%0d want 0",
               bad, rx_b.size(), done_q.size());
    end
  endtask

  task automatic test_basic();
    bit ok, ok2;
    logic [15:0] m;
    m = model(10'h2AD);
    clear_q();
    send(10'h2AD, ok);
    wait_pkts(1, ok2);
    n_cmp++;
    if (!(ok && ok2)) begin
      n_bad++;
      $display("FAIL basic_timeout got %b%b want 11", ok, ok2);
    end else begin
      n_cmp += 5;
      if (rx_b[0] !== m[15:8] || m[15:8] !== 8'hD5) begin
        n_bad++;
        $display("FAIL basic_b0 got %h want %h", rx_b[0], m[15:8]);
      end
      if (rx_b[1] !== m[7:0] || m[7:0] !== 8'h05) begin
        n_bad++;
        $display("FAIL basic_b1 got %h want %h", rx_b[1], m[7:0]);
      end
      if (!(rx_ok[0] && rx_ok[1])) begin
        n_bad++;
        $display("FAIL basic_frame got %b%b want 11", rx_ok[0], rx_ok[1]);
      end
      if (rx_s[1] - rx_s[0] != BYTE_CYC) begin
        n_bad++;
        $display("FAIL basic_spacing got %0d want %0d",
                 rx_s[1] - rx_s[0], BYTE_CYC);
      end
      if (done_q[0] - rx_s[0] != PKT_CYC || low_q[0] != PKT_CYC) begin
        n_bad++;
        $display("FAIL basic_done got %0d/%0d want %0d",
                 done_q[0] - rx_s[0], low_q[0], PKT_CYC);
      end
    end
  endtask

  task automatic test_extremes();
    logic [9:0] smps[2];
    bit ok, ok2;
    int bad;
    logic [15:0] m;
    smps[0] = 10'h3FF;
    smps[1] = 10'h000;
    for (int k = 0; k < 2; k++) begin
      m = model(smps[k]);
      clear_q();
      send(smps[k], ok);
      wait_pkts(1, ok2);
      n_cmp++;
      if (!(ok && ok2)) begin
        n_bad++;
        $display("FAIL ext_timeout got %b%b want 11", ok, ok2);
      end else begin
        n_cmp++;
        if (rx_b[0] !== m[15:8] || rx_b[1] !== m[7:0] ||
            !rx_ok[0] || !rx_ok[1]) begin
          n_bad++;
          $display("FAIL ext_bytes got %h %h want %h %h",
                   rx_b[0], rx_b[1], m[15:8], m[7:0]);
        end
      end
      bad = 0;
      repeat (20) begin
        @(negedge clk);
        if (tx_o !== 1'b1) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL ext_idle got %0d low cycles want 0", bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok, ok2;
    logic [15:0] ma, mb;
    ma = model(10'h155);
    mb = model(10'h0AA);
    clear_q();
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = (sample_ready_o === 1'b1);
    end
    sample_valid_i = 1'b1;
    sample_i = 10'h155;
    @(negedge clk);
    sample_i = 10'h0AA;
    ok2 = 1'b0;
    for (int i = 0; i < 400 && !ok2; i++) begin
      @(negedge clk);
      ok2 = (done_o === 1'b1);
    end
    @(negedge clk);
    sample_valid_i = 1'b0;
    ok = ok && ok2;
    wait_pkts(2, ok2);
    n_cmp++;
    if (!(ok && ok2)) begin
      n_bad++;
      $display("FAIL b2b_timeout got %b%b want 11", ok, ok2);
    end else begin
      n_cmp += 4;
      if (rx_b[0] !== ma[15:8] || rx_b[1] !== ma[7:0] ||
          rx_b[2] !== mb[15:8] || rx_b[3] !== mb[7:0]) begin
        n_bad++;
        $display("FAIL b2b_bytes got %h %h %h %h want %h %h %h %h",
                 rx_b[0], rx_b[1], rx_b[2], rx_b[3],
                 ma[15:8], ma[7:0], mb[15:8], mb[7:0]);
      end
      if (rx_s[2] - done_q[0] != 1) begin
        n_bad++;
        $display("FAIL b2b_gap got %0d want 1", rx_s[2] - done_q[0]);
      end
      if (low_q[0] != PKT_CYC || low_q[1] != PKT_CYC) begin
        n_bad++;
        $display("FAIL b2b_ready_low got %0d %0d want %0d",
                 low_q[0], low_q[1], PKT_CYC);
      end
      if (done_q[1] - rx_s[2] != PKT_CYC ||
          rx_s[3] - rx_s[2] != BYTE_CYC) begin
        n_bad++;
        $display("FAIL b2b_timing got %0d %0d want %0d %0d",
                 done_q[1] - rx_s[2], rx_s[3] - rx_s[2],
                 PKT_CYC, BYTE_CYC);
      end
    end
  endtask

  task automatic test_midflight();
    bit ok, ok2;
    logic [9:0] s;
    logic [15:0] m;
    s = 10'($urandom);
    m = model(s);
    clear_q();
    send(s, ok);
    repeat (20) @(negedge clk);
    sample_i = ~s;
    sample_valid_i = 1'b1;
    @(negedge clk);
    sample_valid_i = 1'b0;
    wait_pkts(1, ok2);
    repeat (150) @(negedge clk);
    n_cmp++;
    if (!(ok && ok2)) begin
      n_bad++;
      $display("FAIL mid_timeout got %b%b want 11", ok, ok2);
    end else begin
      n_cmp += 2;
      if (rx_b[0] !== m[15:8] || rx_b[1] !== m[7:0]) begin
        n_bad++;
        $display("FAIL mid_bytes got %h %h want %h %h",
                 rx_b[0], rx_b[1], m[15:8], m[7:0]);
      end
      if (done_q.size() != 1 || rx_b.size() != 2) begin
        n_bad++;
        $display("FAIL mid_count got %0d dones %0d bytes want 1 2",
                 done_q.size(), rx_b.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, ok2;
    logic [15:0] m;
    m = model(10'h001);
    clear_q();
    send(10'h2AD, ok);
    repeat (8) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (tx_o !== 1'b1 || sample_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_async got tx=%b rdy=%b busy=%b want 1 1 0",
               tx_o, sample_ready_o, busy_o);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    clear_q();
    send(10'h001, ok2);
    ok = ok && ok2;
    wait_pkts(1, ok2);
    n_cmp++;
    if (!(ok && ok2)) begin
      n_bad++;
      $display("FAIL rstmid_timeout got %b%b want 11", ok, ok2);
    end else begin
      n_cmp++;
      if (rx_b[0] !== m[15:8] || rx_b[1] !== m[7:0] ||
          !rx_ok[0] || !rx_ok[1] || rx_s[1] - rx_s[0] != BYTE_CYC) begin
        n_bad++;
        $display("FAIL rstmid_pkt got %h %h sp=%0d want %h %h sp=%0d",
                 rx_b[0], rx_b[1], rx_s[1] - rx_s[0],
                 m[15:8], m[7:0], BYTE_CYC);
      end
    end
  endtask

  task automatic test_random();
    bit ok, ok2;
    logic [9:0] s;
    logic [15:0] m;
    for (int k = 0; k < 8; k++) begin
      s = 10'($urandom);
      m = model(s);
      clear_q();
      send(s, ok);
      wait_pkts(1, ok2);
      n_cmp++;
      if (!(ok && ok2)) begin
        n_bad++;
        $display("FAIL rand_timeout got %b%b want 11", ok, ok2);
      end else begin
        n_cmp++;
        if (rx_b[0] !== m[15:8] || rx_b[1] !== m[7:0] ||
            !rx_ok[0] || !rx_ok[1] ||
            done_q[0] - rx_s[0] != PKT_CYC) begin
          n_bad++;
          $display("FAIL rand_pkt s=%h got %h %h want %h %h",
                   s, rx_b[0], rx_b[1], m[15:8], m[7:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_midflight();
    test_reset_mid();
    test_random();
    n_cmp++;
    if (busy_err != 0) begin
      n_bad++;
      $display("FAIL busy_vs_ready got %0d bad cycles want 0", busy_err);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
